// File: rtl/seq_add_sub.sv
// Multi-cycle adder/subtractor: a WIDTH-bit operand pair is processed CHUNK bits per
// clock through one CHUNK-bit ripple stage with a registered carry between slices.
module seq_add_sub #(
    parameter int WIDTH = 9,
    parameter int CHUNK = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [1:0]       o_state
);

    localparam int NSLICE = (CHUNK < 1) ? 1 : WIDTH / CHUNK;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if (CHUNK < 1 || (WIDTH % ((CHUNK < 1) ? 1 : CHUNK)) != 0) begin : g_bad_param
            $error("seq_add_sub: CHUNK must be >= 1 and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_z;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic             w_last;
    logic [CHUNK-1:0] w_xs;
    logic [CHUNK-1:0] w_ys;
    logic [CHUNK:0]   w_sum;
    logic [WIDTH-1:0] w_z_nxt;

    assign w_last = (r_cnt == CW'(NSLICE - 1));

    // Current slice of the ripple stage; w_z_nxt is the full result as it will
    // stand after this edge, so flags on the final slice see every bit.
    always_comb begin
        w_xs    = r_x[r_cnt*CHUNK +: CHUNK];
        w_ys    = r_y[r_cnt*CHUNK +: CHUNK];
        w_sum   = {1'b0, w_xs} + {1'b0, w_ys} + {{CHUNK{1'b0}}, r_carry};
        w_z_nxt = r_z;
        w_z_nxt[r_cnt*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Subtraction is folded into the operands at accept: x + ~y + ~cin == x - y - cin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x     <= x;
                        r_y     <= sub ? ~y : y;
                        r_carry <= cin ^ sub;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_z     <= w_z_nxt;
                    r_carry <= w_sum[CHUNK];
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_cout <= w_sum[CHUNK];
                        r_ovf  <= (r_x[WIDTH-1] == r_y[WIDTH-1]) &&
                                  (w_z_nxt[WIDTH-1] != r_x[WIDTH-1]);
                        r_zero <= (w_z_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready   = (r_state == S_IDLE);
    assign done    = (r_state == S_DONE);
    assign z       = r_z;
    assign cout    = r_cout;
    assign ovf     = r_ovf;
    assign zero    = r_zero;
    assign o_state = r_state;

endmodule

// File: tb/tb_seq_add_sub.sv
// Directed checks of seq_add_sub at WIDTH=9/CHUNK=3 plus a sweep of three other
// geometries against a signed/unsigned arithmetic reference.
module tb_seq_add_sub;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sub;
    logic [8:0] x;
    logic [8:0] y;
    logic       cin;
    logic       ready;
    logic       done;
    logic [8:0] z;
    logic       cout;
    logic       ovf;
    logic       zero;
    logic [1:0] st;

    logic [2:0]  sw_start;
    logic        sw_sub;
    logic        sw_cin;
    logic [15:0] sw_x;
    logic [15:0] sw_y;
    logic [2:0]  sw_ready;
    logic [2:0]  sw_done;
    logic [2:0]  sw_cout;
    logic [2:0]  sw_ovf;
    logic [2:0]  sw_zero;
    logic [8:0]  sw_z0;
    logic [8:0]  sw_z1;
    logic [15:0] sw_z2;
    logic [1:0]  sw_st0;
    logic [1:0]  sw_st1;
    logic [1:0]  sw_st2;

    int errors = 0;
    int checks = 0;

    seq_add_sub #(.WIDTH(9), .CHUNK(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .x(x), .y(y), .cin(cin),
        .ready(ready), .done(done), .z(z), .cout(cout), .ovf(ovf), .zero(zero), .o_state(st)
    );

    seq_add_sub #(.WIDTH(9), .CHUNK(1)) u_s0 (
        .clk(clk), .rst_n(rst_n), .start(sw_start[0]), .sub(sw_sub), .x(sw_x[8:0]), .y(sw_y[8:0]),
        .cin(sw_cin), .ready(sw_ready[0]), .done(sw_done[0]), .z(sw_z0), .cout(sw_cout[0]),
        .ovf(sw_ovf[0]), .zero(sw_zero[0]), .o_state(sw_st0)
    );

    seq_add_sub #(.WIDTH(9), .CHUNK(9)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(sw_start[1]), .sub(sw_sub), .x(sw_x[8:0]), .y(sw_y[8:0]),
        .cin(sw_cin), .ready(sw_ready[1]), .done(sw_done[1]), .z(sw_z1), .cout(sw_cout[1]),
        .ovf(sw_ovf[1]), .zero(sw_zero[1]), .o_state(sw_st1)
    );

    seq_add_sub #(.WIDTH(16), .CHUNK(4)) u_s2 (
        .clk(clk), .rst_n(rst_n), .start(sw_start[2]), .sub(sw_sub), .x(sw_x), .y(sw_y),
        .cin(sw_cin), .ready(sw_ready[2]), .done(sw_done[2]), .z(sw_z2), .cout(sw_cout[2]),
        .ovf(sw_ovf[2]), .zero(sw_zero[2]), .o_state(sw_st2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called 1 time unit after an edge with the DUT idle; returns 1 time unit
    // after the edge on which done is first seen (lat counts edges from accept).
    task automatic run_op(input logic s, input logic [8:0] a, input logic [8:0] b,
                          input logic c, output int lat);
        start = 1'b1; sub = s; x = a; y = b; cin = c;
        @(posedge clk); #1;
        start = 1'b0;
        x = 9'($urandom); y = 9'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ready, done} !== 2'b10) begin
            errors++; $display("FAIL reset_hs: ready,done=%b expected 10", {ready, done});
        end
        checks++;
        if ({z, cout, ovf, zero} !== 12'h000) begin
            errors++; $display("FAIL reset_out: z=%h flags=%b expected 000/000", z, {cout, ovf, zero});
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        int lat;
        run_op(1'b0, 9'h0FF, 9'h001, 1'b0, lat);
        checks++;
        if (lat != 4) begin errors++; $display("FAIL add1_lat: got %0d expected 4", lat); end
        checks++;
        if ({z, cout, ovf, zero} !== {9'h100, 3'b010}) begin
            errors++; $display("FAIL add1: z=%h flags=%b expected 100/010", z, {cout, ovf, zero});
        end
        @(posedge clk); #1;
        checks++;
        if ({ready, done} !== 2'b10) begin
            errors++; $display("FAIL add1_after: ready,done=%b expected 10", {ready, done});
        end
        run_op(1'b0, 9'h1FF, 9'h001, 1'b0, lat);
        checks++;
        if ({z, cout, ovf, zero} !== {9'h000, 3'b101}) begin
            errors++; $display("FAIL add2: z=%h flags=%b expected 000/101", z, {cout, ovf, zero});
        end
        @(posedge clk); #1;
        run_op(1'b0, 9'h123, 9'h0F0, 1'b1, lat);
        checks++;
        if ({z, cout, ovf, zero} !== {9'h014, 3'b100}) begin
            errors++; $display("FAIL add_cin: z=%h flags=%b expected 014/100", z, {cout, ovf, zero});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sub();
        int lat;
        run_op(1'b1, 9'h005, 9'h007, 1'b0, lat);
        checks++;
        if ({z, cout, ovf, zero} !== {9'h1FE, 3'b000}) begin
            errors++; $display("FAIL sub1: z=%h flags=%b expected 1fe/000", z, {cout, ovf, zero});
        end
        @(posedge clk); #1;
        run_op(1'b1, 9'h010, 9'h00F, 1'b1, lat);
        checks++;
        if ({z, cout, ovf, zero} !== {9'h000, 3'b101}) begin
            errors++; $display("FAIL sub_bin: z=%h flags=%b expected 000/101", z, {cout, ovf, zero});
        end
        @(posedge clk); #1;
        run_op(1'b1, 9'h100, 9'h001, 1'b0, lat);
        checks++;
        if (lat != 4) begin errors++; $display("FAIL sub2_lat: got %0d expected 4", lat); end
        checks++;
        if ({z, cout, ovf, zero} !== {9'h0FF, 3'b110}) begin
            errors++; $display("FAIL sub2: z=%h flags=%b expected 0ff/110", z, {cout, ovf, zero});
        end
        @(posedge clk); #1;
    endtask

    // Previous result is 0x0FF/110; a new accept must not clear it, and starts
    // during RUN and DONE must be dropped.
    task automatic test_ignore_start();
        int          pulses;
        logic [11:0] got;
        got = '0;
        pulses = 0;
        start = 1'b1; sub = 1'b0; x = 9'h0FF; y = 9'h001; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({z, cout, ovf, zero} !== {9'h0FF, 3'b110}) begin
            errors++; $display("FAIL hold_on_accept: z=%h flags=%b expected 0ff/110", z, {cout, ovf, zero});
        end
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin start = 1'b1; sub = 1'b1; x = 9'h1FF; y = 9'h1FF; cin = 1'b1; end
            if (i == 4) start = 1'b0;
            if (done === 1'b1) begin
                pulses++;
                got = {z, cout, ovf, zero};
            end
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL ignore_pulses: got %0d expected 1", pulses); end
        checks++;
        if (got !== {9'h100, 3'b010}) begin
            errors++; $display("FAIL ignore_result: got %h expected %h", got, {9'h100, 3'b010});
        end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL ignore_ready: got %b expected 1", ready); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        int lat;
        pulses = 0;
        start = 1'b1; sub = 1'b1; x = 9'h005; y = 9'h007; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ready, done} !== 2'b10) begin
            errors++; $display("FAIL midrst_hs: ready,done=%b expected 10", {ready, done});
        end
        checks++;
        if ({z, cout, ovf, zero} !== 12'h000) begin
            errors++; $display("FAIL midrst_out: z=%h flags=%b expected 000/000", z, {cout, ovf, zero});
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL midrst_nodone: got %0d expected 0", pulses); end
        run_op(1'b0, 9'h0AA, 9'h055, 1'b0, lat);
        checks++;
        if (lat != 4 || {z, cout, ovf, zero} !== {9'h0FF, 3'b000}) begin
            errors++; $display("FAIL midrst_after: lat=%0d z=%h flags=%b expected 4 0ff/000", lat, z, {cout, ovf, zero});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sweep(input int k, input int w, input int ns);
        longint      mask, half, a, b, r, sa, sb, sr;
        logic [15:0] ez;
        logic [15:0] gz;
        logic        s, c, ecout, eovf, gc, go, gzr;
        int          lat;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        for (int n = 0; n < 2000; n++) begin
            a = longint'($urandom) & mask;
            b = longint'($urandom) & mask;
            s = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            if (n == 0) begin a = mask; b = 1; s = 1'b0; c = 1'b1; end
            if (n == 1) begin a = 0; b = 0; s = 1'b1; c = 1'b1; end
            if (n == 2) begin a = half; b = 1; s = 1'b1; c = 1'b0; end
            if (n == 3) begin a = half - 1; b = 0; s = 1'b0; c = 1'b1; end
            sw_x = a[15:0]; sw_y = b[15:0]; sw_sub = s; sw_cin = c;
            sw_start[k] = 1'b1;
            @(posedge clk); #1;
            sw_start[k] = 1'b0;
            sw_x = 16'($urandom); sw_y = 16'($urandom);
            lat = 1;
            while (sw_done[k] !== 1'b1 && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            case (k)
                0:       gz = {7'b0, sw_z0};
                1:       gz = {7'b0, sw_z1};
                default: gz = sw_z2;
            endcase
            gc = sw_cout[k]; go = sw_ovf[k]; gzr = sw_zero[k];
            r     = s ? (a - b - longint'(c)) : (a + b + longint'(c));
            r     = r & ((longint'(1) << (w + 1)) - 1);
            ez    = 16'(r & mask);
            ecout = s ? (a >= b + longint'(c)) : r[w];
            sa    = (a >= half) ? a - 2 * half : a;
            sb    = (b >= half) ? b - 2 * half : b;
            sr    = s ? (sa - sb - longint'(c)) : (sa + sb + longint'(c));
            eovf  = (sr > half - 1) || (sr < -half);
            checks++;
            if (lat != ns + 1) begin
                errors++; $display("FAIL sweep%0d_lat n=%0d: got %0d expected %0d", k, n, lat, ns + 1);
            end
            checks++;
            if ({gz, gc, go, gzr} !== {ez, ecout, eovf, (ez == 16'h0)}) begin
                errors++;
                $display("FAIL sweep%0d n=%0d a=%h b=%h s=%b c=%b: z=%h flags=%b expected %h/%b",
                         k, n, a[15:0], b[15:0], s, c, gz, {gc, go, gzr}, ez, {ecout, eovf, (ez == 16'h0)});
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        start = 1'b0; sub = 1'b0; x = '0; y = '0; cin = 1'b0;
        sw_start = '0; sw_sub = 1'b0; sw_cin = 1'b0; sw_x = '0; sw_y = '0;
        test_reset();
        test_add();
        test_sub();
        test_ignore_start();
        test_reset_mid();
        test_sweep(0, 9, 9);
        test_sweep(1, 9, 1);
        test_sweep(2, 16, 4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
